// File: rtl/ma_pkg.sv
// ma_pkg: shared FSM/direction types and parameter defaults for the datamover scheduler
package ma_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic {DIR_RD = 1'b0, DIR_WR = 1'b1} dir_t;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_AXI_ADDR_WIDTH = 36;
  localparam int DEF_BRAM_ADDR_WIDTH = 10;
  localparam int DEF_BYTE_TRANS_WIDTH = 15;
  localparam int DEF_MAX_CHUNK = 4096;
  localparam int DEF_BRAM_WORD_BYTES = 16;
endpackage

// File: rtl/ma_dm_scheduler_if.sv
// ma_dm_scheduler_if: channel request/completion and datamover command bundle
interface ma_dm_scheduler_if
  import ma_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int AXI_ADDR_WIDTH = DEF_AXI_ADDR_WIDTH,
  parameter int BRAM_ADDR_WIDTH = DEF_BRAM_ADDR_WIDTH,
  parameter int BYTE_TRANS_WIDTH = DEF_BYTE_TRANS_WIDTH
);
  logic [NUM_CH-1:0] req_valid, req_ready, req_dir, cpl_valid;
  logic [NUM_CH-1:0][AXI_ADDR_WIDTH-1:0] req_axi_addr;
  logic [NUM_CH-1:0][BRAM_ADDR_WIDTH-1:0] req_bram_addr;
  logic [NUM_CH-1:0][BYTE_TRANS_WIDTH-1:0] req_bytes;
  logic dm_start, dm_done;
  logic [AXI_ADDR_WIDTH-1:0] dm_src_axi_addr, dm_dst_axi_addr;
  logic [BRAM_ADDR_WIDTH-1:0] dm_dst_bram_addr, dm_src_bram_addr;
  logic [BYTE_TRANS_WIDTH-1:0] dm_byte_to_trans;
  modport master (
    output req_valid, req_dir, req_axi_addr, req_bram_addr, req_bytes, dm_done,
    input req_ready, cpl_valid, dm_start, dm_src_axi_addr, dm_dst_bram_addr,
    input dm_src_bram_addr, dm_dst_axi_addr, dm_byte_to_trans
  );
  modport slave (
    input req_valid, req_dir, req_axi_addr, req_bram_addr, req_bytes, dm_done,
    output req_ready, cpl_valid, dm_start, dm_src_axi_addr, dm_dst_bram_addr,
    output dm_src_bram_addr, dm_dst_axi_addr, dm_byte_to_trans
  );
endinterface

// File: rtl/ma_rr_arbiter.sv
// ma_rr_arbiter: one-hot round-robin grant, search starts at rr_ptr
module ma_rr_arbiter
  import ma_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] rr_ptr,
  output logic [NUM_CH-1:0] grant
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [PW-1:0] idx;
  // scan farthest-first so the requester closest to rr_ptr wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_CH);
      grant = req[idx] ? NUM_CH'(1) << idx : grant;
    end
  end
endmodule

// File: rtl/ma_dm_scheduler.sv
// ma_dm_scheduler: round-robin scheduler splitting channel transfers into datamover chunks
module ma_dm_scheduler
  import ma_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int AXI_ADDR_WIDTH = DEF_AXI_ADDR_WIDTH,
  parameter int BRAM_ADDR_WIDTH = DEF_BRAM_ADDR_WIDTH,
  parameter int BYTE_TRANS_WIDTH = DEF_BYTE_TRANS_WIDTH,
  parameter int MAX_CHUNK = DEF_MAX_CHUNK,
  parameter int BRAM_WORD_BYTES = DEF_BRAM_WORD_BYTES
) (
  input  logic clk,
  input  logic rst,
  ma_dm_scheduler_if.slave bus,
  output logic busy
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int WS = $clog2(BRAM_WORD_BYTES);
  localparam logic [BYTE_TRANS_WIDTH-1:0] MAXC = BYTE_TRANS_WIDTH'(MAX_CHUNK);
  state_t state;
  dir_t dir, n_dir;
  logic [PW-1:0] rr_ptr, ch, gi;
  logic [NUM_CH-1:0] grant;
  logic [AXI_ADDR_WIDTH-1:0] axi_ptr, n_axi;
  logic [BRAM_ADDR_WIDTH-1:0] bram_ptr, n_bram;
  logic [BYTE_TRANS_WIDTH-1:0] remaining, n_rem, n_chunk;
  logic accept, load;
  ma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (.req(bus.req_valid), .rr_ptr(rr_ptr), .grant(grant));
  assign bus.req_ready = state == ST_IDLE ? grant : '0;
  assign busy = state != ST_IDLE;
  assign accept = state == ST_IDLE && |grant;
  assign load = accept || (state == ST_WAIT && bus.dm_done);
  // index of the granted channel
  always_comb begin
    gi = '0;
    for (int i = 0; i < NUM_CH; i++) gi = grant[i] ? PW'(i) : gi;
  end
  // next command: fresh request fields on accept, advanced pointers after a chunk completes
  always_comb begin
    n_dir = accept ? dir_t'(bus.req_dir[gi]) : dir;
    n_axi = accept ? bus.req_axi_addr[gi] : axi_ptr + AXI_ADDR_WIDTH'(bus.dm_byte_to_trans);
    n_bram = accept ? bus.req_bram_addr[gi] : bram_ptr + BRAM_ADDR_WIDTH'(bus.dm_byte_to_trans >> WS);
    n_rem = accept ? bus.req_bytes[gi] : remaining - bus.dm_byte_to_trans;
    n_chunk = n_rem > MAXC ? MAXC : n_rem;
  end
  // FSM with registered command and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      dir <= DIR_RD;
      rr_ptr <= '0;
      ch <= '0;
      axi_ptr <= '0;
      bram_ptr <= '0;
      remaining <= '0;
      bus.dm_start <= 1'b0;
      bus.dm_byte_to_trans <= '0;
      bus.dm_src_axi_addr <= '0;
      bus.dm_dst_bram_addr <= '0;
      bus.dm_src_bram_addr <= '0;
      bus.dm_dst_axi_addr <= '0;
      bus.cpl_valid <= '0;
    end else begin
      bus.dm_start <= 1'b0;
      bus.cpl_valid <= '0;
      if (load) begin
        dir <= n_dir;
        axi_ptr <= n_axi;
        bram_ptr <= n_bram;
        remaining <= n_rem;
        bus.dm_start <= n_rem != '0;
        bus.dm_byte_to_trans <= n_chunk;
        bus.dm_src_axi_addr <= n_dir == DIR_RD ? n_axi : '0;
        bus.dm_dst_bram_addr <= n_dir == DIR_RD ? n_bram : '0;
        bus.dm_src_bram_addr <= n_dir == DIR_WR ? n_bram : '0;
        bus.dm_dst_axi_addr <= n_dir == DIR_WR ? n_axi : '0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ch <= gi;
            state <= n_rem == '0 ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (bus.dm_done) begin
            state <= n_rem == '0 ? ST_DONE : ST_ISSUE;
            if (n_rem == '0) bus.cpl_valid <= NUM_CH'(1) << ch;
          end
        end
        default: begin
          rr_ptr <= ch == PW'(NUM_CH - 1) ? '0 : ch + 1'b1;
          state <= ST_IDLE;
          if (~|bus.cpl_valid) bus.cpl_valid <= NUM_CH'(1) << ch;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ma_dm_scheduler.sv
// tb_ma_dm_scheduler: randomized self-checking bench against a chunking/round-robin reference model
module tb_ma_dm_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int n_checks = 0;
  int n_errors = 0;
  ma_dm_scheduler_if bus ();
  ma_dm_scheduler dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_exp;
  logic [35:0] exp_axi [16];
  logic [9:0] exp_bram [16];
  int exp_bytes [16];
  int n_obs, cyc_cpl, start_bad, stable_bad;
  int obs_cyc [16];
  int done_cyc [16];
  int obs_bytes [16];
  logic [35:0] obs_sa [16];
  logic [35:0] obs_da [16];
  logic [9:0] obs_sb [16];
  logic [9:0] obs_db [16];
  logic [3:0] rdy_obs, cpl_obs, post_cpl;
  logic post_busy;

  // reference: a transfer is a run of MAX_CHUNK pieces, addresses advancing by bytes and words
  function automatic void build_model(input logic [35:0] axi, input logic [9:0] bram, input int bytes);
    n_exp = 0;
    for (int off = 0; off < bytes; off += 4096) begin
      exp_bytes[n_exp] = (bytes - off > 4096) ? 4096 : bytes - off;
      exp_axi[n_exp] = axi + 36'(off);
      exp_bram[n_exp] = bram + 10'(off / 16);
      n_exp++;
    end
  endfunction

  // reference: first requesting channel at or after ptr, wrapping
  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int j = 0; j < 4; j++) if (mask[(ptr + j) % 4]) return (ptr + j) % 4;
    return -1;
  endfunction

  // single-channel request; plays the datamover and records everything the DUT emits
  task automatic xfer(input int ch, input logic dir, input logic [35:0] axi, input logic [9:0] bram, input int bytes);
    int wait_cnt = 0;
    logic in_cmd = 1'b0;
    n_obs = 0;
    cyc_cpl = -1;
    start_bad = 0;
    stable_bad = 0;
    cpl_obs = '0;
    bus.req_valid = '0;
    bus.req_valid[ch] = 1'b1;
    bus.req_dir[ch] = dir;
    bus.req_axi_addr[ch] = axi;
    bus.req_bram_addr[ch] = bram;
    bus.req_bytes[ch] = 15'(bytes);
    #1 rdy_obs = bus.req_ready;
    @(negedge clk);
    bus.req_valid = '0;
    for (int k = 1; k < 300 && cyc_cpl < 0; k++) begin
      if (in_cmd) begin
        if (bus.dm_start) start_bad++;
        if (bus.dm_src_axi_addr !== obs_sa[n_obs-1] || bus.dm_dst_axi_addr !== obs_da[n_obs-1] ||
            bus.dm_src_bram_addr !== obs_sb[n_obs-1] || bus.dm_dst_bram_addr !== obs_db[n_obs-1] ||
            int'(bus.dm_byte_to_trans) != obs_bytes[n_obs-1]) stable_bad++;
      end else if (bus.dm_start && n_obs < 16) begin
        obs_sa[n_obs] = bus.dm_src_axi_addr;
        obs_da[n_obs] = bus.dm_dst_axi_addr;
        obs_sb[n_obs] = bus.dm_src_bram_addr;
        obs_db[n_obs] = bus.dm_dst_bram_addr;
        obs_bytes[n_obs] = int'(bus.dm_byte_to_trans);
        obs_cyc[n_obs] = k;
        n_obs++;
        in_cmd = 1'b1;
        wait_cnt = $urandom_range(2, 5);
      end
      if (bus.cpl_valid !== '0) begin
        cpl_obs = bus.cpl_valid;
        cyc_cpl = k;
      end
      bus.dm_done = 1'b0;
      if (in_cmd) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          bus.dm_done = 1'b1;
          done_cyc[n_obs-1] = k;
          in_cmd = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.dm_done = 1'b0;
    post_cpl = bus.cpl_valid;
    post_busy = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_dir = '0;
    bus.req_axi_addr = '0;
    bus.req_bram_addr = '0;
    bus.req_bytes = '0;
    bus.dm_done = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bus.dm_start !== 1'b0 || bus.cpl_valid !== '0) begin
      n_errors++;
      $display("FAIL reset_ctl: busy=%b start=%b cpl=%b, want 0 0 0", busy, bus.dm_start, bus.cpl_valid);
    end
    n_checks++;
    if (bus.dm_src_axi_addr !== '0 || bus.dm_dst_axi_addr !== '0 || bus.dm_src_bram_addr !== '0 ||
        bus.dm_dst_bram_addr !== '0 || bus.dm_byte_to_trans !== '0) begin
      n_errors++;
      $display("FAIL reset_cmd: sa=%h da=%h sb=%h db=%h n=%h, want all 0", bus.dm_src_axi_addr,
               bus.dm_dst_axi_addr, bus.dm_src_bram_addr, bus.dm_dst_bram_addr, bus.dm_byte_to_trans);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    xfer(0, 1'b0, 36'h1000, 10'h010, 256);
    n_checks++;
    if (rdy_obs !== 4'b0001) begin
      n_errors++;
      $display("FAIL single_ready: got %b want 0001", rdy_obs);
    end
    n_checks++;
    if (n_obs != 1 || obs_cyc[0] != 1) begin
      n_errors++;
      $display("FAIL single_start: got %0d cmds first at cycle %0d, want 1 at cycle 1", n_obs, obs_cyc[0]);
    end
    n_checks++;
    if (obs_sa[0] !== 36'h1000 || obs_db[0] !== 10'h010 || obs_sb[0] !== '0 || obs_da[0] !== '0 || obs_bytes[0] != 256) begin
      n_errors++;
      $display("FAIL single_cmd: sa=%h db=%h sb=%h da=%h n=%0d, want 1000 010 0 0 256", obs_sa[0], obs_db[0], obs_sb[0], obs_da[0], obs_bytes[0]);
    end
    n_checks++;
    if (cpl_obs !== 4'b0001 || cyc_cpl != done_cyc[0] + 1 || post_cpl !== '0 || post_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL single_cpl: cpl=%b at %0d (done %0d) post=%b busy=%b, want 0001 at done+1 then 0", cpl_obs, cyc_cpl, done_cyc[0], post_cpl, post_busy);
    end
    n_checks++;
    if (stable_bad != 0 || start_bad != 0) begin
      n_errors++;
      $display("FAIL single_stable: unstable=%0d extra_start=%0d, want 0 0", stable_bad, start_bad);
    end
  endtask

  task automatic test_ready_gating();
    bus.req_bytes = '0;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    n_checks++;
    if (bus.req_ready !== '0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_gating: ready=%b busy=%b, want 0000 1", bus.req_ready, busy);
    end
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_multi_chunk();
    logic [63:0] r = {$urandom, $urandom};
    logic [35:0] axi = r[35:0];
    logic [9:0] bram = 10'($urandom);
    int want [3] = '{4096, 4096, 1808};
    xfer(2, 1'b1, axi, bram, 10000);
    n_checks++;
    if (n_obs != 3 || cpl_obs !== 4'b0100) begin
      n_errors++;
      $display("FAIL multi_count: %0d cmds cpl=%b, want 3 0100", n_obs, cpl_obs);
    end
    for (int i = 0; i < 3 && i < n_obs; i++) begin
      n_checks++;
      if (obs_bytes[i] != want[i] || obs_da[i] !== axi + 36'(i * 4096) || obs_sb[i] !== bram + 10'(i * 256) ||
          obs_sa[i] !== '0 || obs_db[i] !== '0) begin
        n_errors++;
        $display("FAIL multi_cmd%0d: n=%0d da=%h sb=%h sa=%h db=%h, want n=%0d da=%h sb=%h 0 0", i, obs_bytes[i],
                 obs_da[i], obs_sb[i], obs_sa[i], obs_db[i], want[i], axi + 36'(i * 4096), bram + 10'(i * 256));
      end
      n_checks++;
      if (i > 0 && obs_cyc[i] != done_cyc[i-1] + 1) begin
        n_errors++;
        $display("FAIL multi_lat%0d: start at %0d, want %0d", i, obs_cyc[i], done_cyc[i-1] + 1);
      end
    end
  endtask

  task automatic test_wrap();
    xfer(1, 1'b0, 36'hF_FFFF_F000, 10'h3F0, 8192);
    n_checks++;
    if (n_obs != 2 || obs_sa[0] !== 36'hF_FFFF_F000 || obs_sa[1] !== '0 || obs_db[0] !== 10'h3F0 || obs_db[1] !== 10'h0F0) begin
      n_errors++;
      $display("FAIL wrap_rd: %0d cmds sa=%h,%h db=%h,%h, want 2 FFFFFF000,0 3F0,0F0", n_obs, obs_sa[0], obs_sa[1], obs_db[0], obs_db[1]);
    end
    xfer(3, 1'b1, 36'hF_FFFF_F000, 10'h3F0, 8192);
    n_checks++;
    if (n_obs != 2 || obs_da[1] !== '0 || obs_sb[1] !== 10'h0F0 || cpl_obs !== 4'b1000) begin
      n_errors++;
      $display("FAIL wrap_wr: %0d cmds da=%h sb=%h cpl=%b, want 2 0 0F0 1000", n_obs, obs_da[1], obs_sb[1], cpl_obs);
    end
  endtask

  task automatic test_zero_bytes();
    int ch = $urandom_range(0, 3);
    xfer(ch, 1'($urandom), 36'($urandom), 10'($urandom), 0);
    n_checks++;
    if (n_obs != 0 || cyc_cpl != 2 || cpl_obs !== 4'(1 << ch) || post_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_bytes: %0d cmds cpl=%b at %0d busy=%b, want 0 cmds cpl=%b at 2 busy 0", n_obs, cpl_obs, cyc_cpl, post_busy, 4'(1 << ch));
    end
  endtask

  task automatic test_arbitration();
    int ptr = 0;
    int ng = 0;
    int g, guard;
    logic [3:0] mask;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.req_bytes = '0;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 40 && ng < 5; k++) begin
      #1;
      if (bus.req_ready !== '0) begin
        g = rr_pick(4'b1111, ptr);
        n_checks++;
        if (bus.req_ready !== 4'(1 << g)) begin
          n_errors++;
          $display("FAIL rr_seq%0d: ready=%b want %b", ng, bus.req_ready, 4'(1 << g));
        end
        ptr = (g + 1) % 4;
        ng++;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    n_checks++;
    if (ng != 5) begin
      n_errors++;
      $display("FAIL rr_count: saw %0d grants want 5", ng);
    end
    ptr = 0;
    for (int r = 0; r < 16; r++) begin
      guard = 0;
      while (busy && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      mask = 4'($urandom_range(1, 15));
      bus.req_valid = mask;
      #1;
      g = rr_pick(mask, ptr);
      n_checks++;
      if (bus.req_ready !== 4'(1 << g) || guard >= 20) begin
        n_errors++;
        $display("FAIL rr_rand%0d: mask=%b ready=%b want %b", r, mask, bus.req_ready, 4'(1 << g));
      end
      ptr = (g + 1) % 4;
      @(negedge clk);
      bus.req_valid = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int bad = 0;
    bus.req_bytes[1] = 15'd256;
    bus.req_dir[1] = 1'b0;
    bus.req_valid = 4'b0010;
    #1;
    n_checks++;
    if (bus.req_ready === '0) begin
      n_errors++;
      $display("FAIL rst_wait_accept: ready=%b want nonzero", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_wait_busy: busy=%b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.dm_done = 1'b1;
    @(negedge clk);
    bus.dm_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.cpl_valid !== '0 || bus.dm_start !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL rst_wait_quiet: %0d cycles with cpl/start/busy, want 0", bad);
    end
    bus.req_bytes = '0;
    bus.req_valid = 4'b1111;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_errors++;
      $display("FAIL rst_wait_rrptr: ready=%b want 0001", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random_transfers();
    for (int t = 0; t < 12; t++) begin
      int ch = $urandom_range(0, 3);
      logic dir = 1'($urandom);
      logic [63:0] r = {$urandom, $urandom};
      logic [35:0] axi = r[35:0];
      logic [9:0] bram = 10'($urandom);
      int sel = $urandom_range(0, 3);
      int bytes = sel == 0 ? 0 : sel == 1 ? 4096 * $urandom_range(1, 4) : $urandom_range(1, 20000);
      int exp_cc;
      build_model(axi, bram, bytes);
      xfer(ch, dir, axi, bram, bytes);
      n_checks++;
      if (n_obs != n_exp) begin
        n_errors++;
        $display("FAIL rand%0d_count: %0d cmds want %0d (bytes %0d)", t, n_obs, n_exp, bytes);
      end
      for (int i = 0; i < n_exp && i < n_obs; i++) begin
        n_checks++;
        if (obs_sa[i] !== (dir ? 36'd0 : exp_axi[i]) || obs_da[i] !== (dir ? exp_axi[i] : 36'd0) ||
            obs_db[i] !== (dir ? 10'd0 : exp_bram[i]) || obs_sb[i] !== (dir ? exp_bram[i] : 10'd0) ||
            obs_bytes[i] != exp_bytes[i]) begin
          n_errors++;
          $display("FAIL rand%0d_cmd%0d: sa=%h da=%h sb=%h db=%h n=%0d, want dir=%0d axi=%h bram=%h n=%0d",
                   t, i, obs_sa[i], obs_da[i], obs_sb[i], obs_db[i], obs_bytes[i], dir, exp_axi[i], exp_bram[i], exp_bytes[i]);
        end
        n_checks++;
        if (obs_cyc[i] != (i == 0 ? 1 : done_cyc[i-1] + 1)) begin
          n_errors++;
          $display("FAIL rand%0d_lat%0d: start at %0d want %0d", t, i, obs_cyc[i], i == 0 ? 1 : done_cyc[i-1] + 1);
        end
      end
      exp_cc = n_exp == 0 ? 2 : (n_obs > 0 ? done_cyc[n_obs-1] + 1 : -2);
      n_checks++;
      if (cpl_obs !== 4'(1 << ch) || cyc_cpl != exp_cc) begin
        n_errors++;
        $display("FAIL rand%0d_cpl: cpl=%b at %0d, want %b at %0d", t, cpl_obs, cyc_cpl, 4'(1 << ch), exp_cc);
      end
      n_checks++;
      if (stable_bad != 0 || start_bad != 0 || post_cpl !== '0 || post_busy !== 1'b0) begin
        n_errors++;
        $display("FAIL rand%0d_tail: unstable=%0d extra_start=%0d post_cpl=%b busy=%b, want 0 0 0000 0",
                 t, stable_bad, start_bad, post_cpl, post_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ready_gating();
    test_multi_chunk();
    test_wrap();
    test_zero_bytes();
    test_arbitration();
    test_reset_in_wait();
    test_random_transfers();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ma_dm_scheduler.md
MA_DM_SCHEDULER -- requirements
Module: ma_dm_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requesting channels.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 36: AXI byte address width.
REQ-003 SHALL have parameter BRAM_ADDR_WIDTH, default 10: BRAM word address width.
REQ-004 SHALL have parameter BYTE_TRANS_WIDTH, default 15: byte-count width.
REQ-005 SHALL have parameter MAX_CHUNK, default 4096: max bytes per datamover command; power of two, multiple of BRAM_WORD_BYTES.
REQ-006 SHALL have parameter BRAM_WORD_BYTES, default 16: bytes per BRAM word; power of two.
REQ-007 SHALL use one clock and a synchronous, active-high reset, as the following two port lines state.
REQ-008 clk  in  1  sole clock; all logic on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 req_valid  in  NUM_CH  per-channel request valid.
REQ-011 req_ready  out  NUM_CH  per-channel accept; one-hot or zero.
REQ-012 req_dir  in  NUM_CH  0 = AXI->BRAM (read), 1 = BRAM->AXI (write).
REQ-013 req_axi_addr  in  NUM_CH x AXI_ADDR_WIDTH  AXI start address.
REQ-014 req_bram_addr  in  NUM_CH x BRAM_ADDR_WIDTH  BRAM start word address.
REQ-015 req_bytes  in  NUM_CH x BYTE_TRANS_WIDTH  total bytes.
REQ-016 cpl_valid  out  NUM_CH  one-cycle completion pulse per channel.
REQ-017 busy  out  1  high when not IDLE.
REQ-018 dm_start, dm_src_axi_addr, dm_dst_bram_addr, dm_src_bram_addr, dm_dst_axi_addr, dm_byte_to_trans  out  (1, AXI, BRAM, BRAM, AXI, BYTE_TRANS)  datamover command, master side.
REQ-019 dm_done  in  1  datamover completion pulse.

Function
REQ-020 SHALL implement FSM IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
REQ-021 IDLE: round-robin grant among asserted req_valid, starting at rr_ptr; req_ready high only for granted channel, same cycle, combinationally from req_valid; accept on valid&ready; latch dir, addresses, bytes; go ISSUE.
REQ-022 req_ready SHALL be all-zero outside IDLE.
REQ-023 ISSUE: dm_start high exactly one cycle; chunk = min(remaining, MAX_CHUNK) on dm_byte_to_trans; go WAIT.
REQ-024 dir 0 drives dm_src_axi_addr/dm_dst_bram_addr from current pointers, other two address outputs 0; dir 1 drives dm_src_bram_addr/dm_dst_axi_addr, other two 0.
REQ-025 Address outputs and dm_byte_to_trans SHALL be registered and stable from ISSUE through WAIT.
REQ-026 WAIT on dm_done: remaining -= chunk; axi pointer += chunk, modulo 2^AXI_ADDR_WIDTH; bram pointer += chunk/BRAM_WORD_BYTES, modulo 2^BRAM_ADDR_WIDTH; remaining == 0 -> DONE, else ISSUE next cycle.
REQ-027 DONE: cpl_valid[granted] high one cycle; rr_ptr <= granted+1 mod NUM_CH; go IDLE.
REQ-028 req_bytes == 0: accepted, no dm_start, IDLE -> DONE directly.
REQ-029 dm_done outside WAIT SHALL be ignored.
REQ-030 Latency: accept at cycle N -> dm_start at N+1; dm_done at M -> next dm_start or cpl_valid at M+1.

Reset
REQ-031 rst SHALL force IDLE, rr_ptr=0, all outputs 0, pointers/remaining 0; mid-transfer reset abandons command without cpl_valid; dm_done after reset ignored.

Structure
REQ-032 Shared package ma_pkg SHALL hold FSM state enum, direction enum, parameter defaults.
REQ-033 Round-robin grant logic SHALL be sub-module ma_rr_arbiter (NUM_CH, req, rr_ptr -> one-hot grant).

Verification
REQ-034 ch0 dir0 axi 0x1000 bram 0x010 bytes 256 -> one dm_start, src_axi 0x1000, dst_bram 0x010, bytes 256; dm_done -> cpl_valid[0] next cycle.
REQ-035 ch2 dir1 bytes 10000 -> three commands 4096/4096/1808; bram +256 words, axi +0x1000 each.
REQ-036 all 4 channels valid continuously -> grants 0,1,2,3,0 in order.
REQ-037 axi 0xF_FFFF_F000 bytes 8192 -> second command at axi 0x0; bram 0x3F0 bytes 8192 -> second at 0x0F0.
REQ-038 bytes 0 -> no dm_start, cpl_valid 2 cycles after accept.
REQ-039 rst in WAIT then dm_done -> IDLE, no cpl_valid, no dm_start.
